// File: rtl/pwm_ramp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_pkg
//  Description : Shared types and constants for the PWM soft-start/soft-stop
//                speed ramp sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_ramp_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        STOP = 2'd3
    } ramp_state_t;

    // Default widths of the speed code and the dwell counter
    localparam int SPEED_W_DEF = 3;
    localparam int DWELL_W_DEF = 16;

    // Speed code limits for the default speed width
    localparam int SPEED_ZERO = 0;
    localparam int SPEED_MAX  = (1 << SPEED_W_DEF) - 1;

endpackage : pwm_ramp_pkg
`default_nettype wire

// File: rtl/ramp_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ramp_tick_gen
//  Description : Dwell counter. Raises tick once every dwell clock cycles
//                (a dwell of 0 behaves as 1). restart clears the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module ramp_tick_gen #(
    parameter int DWELL_W = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               restart_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               tick_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [DWELL_W-1:0] limit_w;

    // Terminal count; >= makes a lowered dwell tick immediately
    always_comb begin
        limit_w = (dwell_i == '0) ? '0 : (dwell_i - 1'b1);
        tick_o  = (cnt_q >= limit_w);
        cnt_d   = (restart_i || tick_o) ? '0 : (cnt_q + 1'b1);
    end

    // Count register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : ramp_tick_gen
`default_nettype wire

// File: rtl/pwm_speed_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_speed_ramp
//  Description : Soft-start/soft-stop sequencer feeding the PWM width
//                generator. Steps speed by +/-1 per dwell period and ramps
//                to 0 before dropping the enable.
//                Optional macro SPEED_RAMP_ESTOP_EN adds an emergency stop
//                input that forces OFF immediately.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_speed_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int SPEED_W = SPEED_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               run_i,
    input  logic [SPEED_W-1:0] target_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef SPEED_RAMP_ESTOP_EN
    input  logic               estop_i,
`endif
    output logic [SPEED_W-1:0] speed_o,
    output logic               pwm_enable_o,
    output logic               at_target_o,
    output logic               busy_o
);

    localparam logic [SPEED_W-1:0] C_SPD_ZERO = SPEED_W'(SPEED_ZERO);
    localparam logic [SPEED_W-1:0] C_SPD_MAX  = {SPEED_W{1'b1}};

    ramp_state_t        state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               enable_q, enable_d;
    logic               at_target_q, at_target_d;
    logic               busy_q, busy_d;
    logic               tick_w;
    logic               restart_w;

    // The dwell timer restarts whenever the state changes
    assign restart_w = (state_d != state_q);

    ramp_tick_gen #(
        .DWELL_W (DWELL_W)
    ) u_tick (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .restart_i (restart_w),
        .dwell_i   (dwell_i),
        .tick_o    (tick_w)
    );

    // Next-state, next-speed and next-output decode
    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        unique case (state_q)
            OFF: begin
                speed_d = C_SPD_ZERO;
                if (run_i) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!run_i) begin
                    state_d = (speed_q == C_SPD_ZERO) ? OFF : STOP;
                end else if (speed_q == target_i) begin
                    state_d = HOLD;
                end else if (tick_w) begin
                    // Direction re-evaluated every step; never past the limits
                    if ((target_i > speed_q) && (speed_q != C_SPD_MAX)) begin
                        speed_d = speed_q + 1'b1;
                    end else if ((target_i < speed_q) && (speed_q != C_SPD_ZERO)) begin
                        speed_d = speed_q - 1'b1;
                    end
                    if (speed_d == target_i) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!run_i) begin
                    state_d = (speed_q == C_SPD_ZERO) ? OFF : STOP;
                end else if (target_i != speed_q) begin
                    state_d = RAMP;
                end
            end
            STOP: begin
                // Resuming keeps the current speed; reaching 0 lets one
                // more cycle pass before enable is dropped
                if (run_i) begin
                    state_d = RAMP;
                end else if (speed_q == C_SPD_ZERO) begin
                    state_d = OFF;
                end else if (tick_w) begin
                    speed_d = speed_q - 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                speed_d = C_SPD_ZERO;
            end
        endcase
`ifdef SPEED_RAMP_ESTOP_EN
        // Emergency stop overrides every other input
        if (estop_i) begin
            state_d = OFF;
            speed_d = C_SPD_ZERO;
        end
`endif
        enable_d    = (state_d != OFF);
        at_target_d = (state_d == HOLD);
        busy_d      = (state_d == RAMP) || (state_d == STOP);
    end

    // State, speed and registered status outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= OFF;
            speed_q     <= C_SPD_ZERO;
            enable_q    <= 1'b0;
            at_target_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            enable_q    <= enable_d;
            at_target_q <= at_target_d;
            busy_q      <= busy_d;
        end
    end

    assign speed_o      = speed_q;
    assign pwm_enable_o = enable_q;
    assign at_target_o  = at_target_q;
    assign busy_o       = busy_q;

endmodule : pwm_speed_ramp
`default_nettype wire

// File: tb/tb_pwm_speed_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_speed_ramp
//  Description : Self-checking bench for pwm_speed_ramp. A table of
//                {cycles, inputs, expected outputs} records walks through
//                soft start, redirect, soft stop, dwell=0 saturation and
//                resume from STOP; short hand sequences cover reset mid-ramp,
//                lowering dwell mid-count and (with SPEED_RAMP_ESTOP_EN)
//                the emergency stop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_speed_ramp;

    logic        clk;
    logic        rst;
    logic        run;
    logic [2:0]  target;
    logic [15:0] dwell;
    logic [2:0]  speed;
    logic        pwm_enable;
    logic        at_target;
    logic        busy;
`ifdef SPEED_RAMP_ESTOP_EN
    logic        estop;
`endif

    int checks;
    int errors;

    typedef struct {
        int          n;
        logic        run;
        logic [2:0]  target;
        logic [15:0] dwell;
        logic [2:0]  spd;
        logic        en;
        logic        at;
        logic        bsy;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    pwm_speed_ramp #(
        .SPEED_W (3),
        .DWELL_W (16)
    ) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .run_i        (run),
        .target_i     (target),
        .dwell_i      (dwell),
`ifdef SPEED_RAMP_ESTOP_EN
        .estop_i      (estop),
`endif
        .speed_o      (speed),
        .pwm_enable_o (pwm_enable),
        .at_target_o  (at_target),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] e_spd,
                         input logic e_en, input logic e_at, input logic e_bsy);
        checks++;
        if ({speed, pwm_enable, at_target, busy} !== {e_spd, e_en, e_at, e_bsy}) begin
            errors++;
            $display("FAIL %s: got speed=%0d en=%b at=%b busy=%b, expected speed=%0d en=%b at=%b busy=%b",
                     name, speed, pwm_enable, at_target, busy, e_spd, e_en, e_at, e_bsy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          n   run   tgt    dwell   spd   en    at    busy
        // Soft start 0->5, dwell 4
        vecs[0]  = '{1,  1'b1, 3'd5, 16'd4, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3,  1'b1, 3'd5, 16'd4, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1,  1'b1, 3'd5, 16'd4, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{4,  1'b1, 3'd5, 16'd4, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{4,  1'b1, 3'd5, 16'd4, 3'd3, 1'b1, 1'b0, 1'b1};
        // Redirect at speed 3 toward 1, no overshoot
        vecs[5]  = '{3,  1'b1, 3'd1, 16'd4, 3'd3, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1,  1'b1, 3'd1, 16'd4, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4,  1'b1, 3'd1, 16'd4, 3'd1, 1'b1, 1'b1, 1'b0};
        // HOLD exit on new target, ramp 1->5
        vecs[8]  = '{1,  1'b1, 3'd5, 16'd4, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16, 1'b1, 3'd5, 16'd4, 3'd5, 1'b1, 1'b1, 1'b0};
        // Soft stop from 5, dwell 2: 0 after 10 cycles, enable off one later
        vecs[10] = '{1,  1'b0, 3'd5, 16'd2, 3'd5, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{2,  1'b0, 3'd5, 16'd2, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{8,  1'b0, 3'd5, 16'd2, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1,  1'b0, 3'd5, 16'd2, 3'd0, 1'b0, 1'b0, 1'b0};
        // dwell 0 behaves as 1, saturates at 7
        vecs[14] = '{1,  1'b1, 3'd7, 16'd0, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1,  1'b1, 3'd7, 16'd0, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{6,  1'b1, 3'd7, 16'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{5,  1'b1, 3'd7, 16'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        // Stop down to 2, then resume from 2
        vecs[18] = '{1,  1'b0, 3'd7, 16'd0, 3'd7, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{5,  1'b0, 3'd7, 16'd0, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{1,  1'b1, 3'd7, 16'd0, 3'd2, 1'b1, 1'b0, 1'b1};
        vecs[21] = '{1,  1'b1, 3'd7, 16'd0, 3'd3, 1'b1, 1'b0, 1'b1};

        rst    = 1'b1;
        run    = 1'b0;
        target = 3'd0;
        dwell  = 16'd0;
`ifdef SPEED_RAMP_ESTOP_EN
        estop  = 1'b0;
`endif
        step();
        step();
        check("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run    = vecs[i].run;
            target = vecs[i].target;
            dwell  = vecs[i].dwell;
            repeat (vecs[i].n) step();
            check($sformatf("vec%0d", i), vecs[i].spd, vecs[i].en, vecs[i].at, vecs[i].bsy);
        end

        // Synchronous reset mid-ramp: reset values at the next edge
        rst = 1'b1;
        step();
        check("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Lowering dwell mid-count ticks at once
        run    = 1'b1;
        target = 3'd5;
        dwell  = 16'd8;
        step();
        check("dwell8_entry", 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        check("dwell8_wait", 3'd0, 1'b1, 1'b0, 1'b1);
        dwell = 16'd2;
        step();
        check("dwell_lowered", 3'd1, 1'b1, 1'b0, 1'b1);

        // Stop straight to OFF when run drops at speed 0
        rst = 1'b1;
        step();
        rst    = 1'b0;
        run    = 1'b1;
        target = 3'd3;
        dwell  = 16'd4;
        step();
        run = 1'b0;
        step();
        check("stop_at_zero", 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef SPEED_RAMP_ESTOP_EN
        // Emergency stop at speed 6, held 5 cycles, released with run=1
        run    = 1'b1;
        target = 3'd6;
        dwell  = 16'd0;
        step();
        repeat (6) step();
        check("estop_pre", 3'd6, 1'b1, 1'b1, 1'b0);
        estop = 1'b1;
        step();
        check("estop_hit", 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("estop_hold%0d", k), 3'd0, 1'b0, 1'b0, 1'b0);
        end
        estop = 1'b0;
        step();
        check("estop_release", 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        check("estop_ramp", 3'd1, 1'b1, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pwm_speed_ramp
`default_nettype wire
